level_pulse_gen: RTL

//  Inverse of the level counter: takes a hold count and drives lv_out high for exactly

---
 rtl/level_pulse_gen.sv | 116 +++++++++++
 1 files changed

// File: rtl/level_pulse_gen.sv
// Replays a level of hold_in slow ticks on lv_out. The slow tick comes from an internal prescaler.
// A start/busy/done handshake goes to the controlling logic. All outputs are registered.
module level_pulse_gen #(
  parameter int unsigned count_max = 8,
  parameter int unsigned TICK_DIV  = 50_000_000
) (
  input  logic                 CLK100MHZ,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 cancel,
  input  logic [count_max-1:0] hold_in,
  output logic                 lv_out,
  output logic                 busy,
  output logic                 done,
  output logic [count_max-1:0] remaining
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  logic [1:0]           state_q, state_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [count_max-1:0] rem_q, rem_d;
  logic                 lv_q, lv_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 tick;

  assign tick = (presc_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    rem_d   = rem_q;
    lv_d    = lv_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          presc_d = '0;
          if (hold_in != '0) begin
            state_d = HOLD;
            rem_d   = hold_in;
            lv_d    = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      HOLD: begin
        // Cancel takes priority over the final tick, so no done is produced.
        if (cancel) begin
          state_d = IDLE;
          presc_d = '0;
          rem_d   = '0;
          lv_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (tick) begin
          presc_d = '0;
          if (rem_q == count_max'(1)) begin
            state_d = DONE;
            rem_d   = '0;
            lv_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            rem_d = rem_q - 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        presc_d = '0;
        rem_d   = '0;
        lv_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      rem_q   <= '0;
      lv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      rem_q   <= rem_d;
      lv_q    <= lv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign lv_out    = lv_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = rem_q;

endmodule
